sdram_init_seq: RTL and testbench
=================================

Name: sdram_init_seq

Overview:
- SDRAM power-up initialization sequencer in the sdram_clk domain.
- After sdram_en rises, it drives the JEDEC init command stream onto the SDRAM command pins: power-up NOP wait, PRECHARGE ALL, NUM_REF AUTO REFRESH commands, then LOAD MODE REGISTER. It then raises init_done.
- It is the upstream producer of the command stream that the whitebox sdram_init assertion checks. The request/refresh controller may issue commands only after init_done.

Parameters:
- SDR_AW, 13, SDRAM address bus width.
- INIT_WAIT, 10000, power-up NOP cycles after sdram_en rises.
- CMD_HOLD, 2, consecutive cycles each non-NOP command is driven.
- NUM_REF, 2, AUTO REFRESH commands issued during init.

Ports:
- sdram_clk  in  1  controller clock.
- sdram_resetn  in  1  synchronous active-low reset.
- sdram_en  in  1  enable; a rising edge starts init, low aborts.
- cfg_mode_reg  in  SDR_AW  value driven on sdr_addr during LMR.
- cfg_trp_d  in  4  NOP cycles after PRECHARGE (0 = none).
- cfg_trfc_d  in  4  NOP cycles after each REFRESH (0 = none).
- cfg_tmrd_d  in  4  NOP cycles after LMR (0 = none).
- init_busy  out  1  high in any state except IDLE/DONE.
- init_done  out  1  init complete; sticky.
- sdr_cke  out  1  clock enable.
- sdr_cs_n  out  1  chip select.
- sdr_ras_n  out  1  RAS.
- sdr_cas_n  out  1  CAS.
- sdr_we_n  out  1  WE.
- sdr_addr  out  SDR_AW  address.
- sdr_ba  out  2  bank address.

Behaviour:
- Clock and reset: sdram_clk is the only clock. Reset is synchronous and active-low on sdram_resetn.
- Reset values (all outputs registered): cke=0, cs_n=0, ras_n/cas_n/we_n=1 (NOP), addr=0, ba=0, init_busy=0, init_done=0, state=IDLE, en_q=0, counters=0.
- Command encodings {ras_n,cas_n,we_n}:
  - NOP = 111.
  - PRECHARGE = 010, with addr[10]=1 (all banks) and other addr bits 0.
  - REFRESH = 001.
  - LMR = 000, with addr=cfg_mode_reg and ba=0.
- cs_n is 0 in every state.
- Start: a rising edge is detected when sdram_en=1 and en_q=0. On that edge the FSM enters PWR_WAIT. The pins show NOP on the cycle after sdram_en rises.
- FSM states and exit conditions:
  - IDLE: cke=0, NOP.
  - PWR_WAIT: cke=1, NOP for exactly INIT_WAIT cycles.
  - PRE: PRECHARGE for CMD_HOLD cycles.
  - TRP: NOP for cfg_trp_d cycles; skipped if 0.
  - REF: REFRESH for CMD_HOLD cycles.
  - TRFC: NOP for cfg_trfc_d cycles; skipped if 0. Then the refresh counter increments; go to REF if count<NUM_REF, else LMR.
  - LMR: LMR command for CMD_HOLD cycles.
  - TMRD: NOP for cfg_tmrd_d cycles; skipped if 0.
  - DONE: cke=1, NOP, init_done=1.
- Counters:
  - Wait counter width is $clog2(INIT_WAIT+1) and reloads on each state entry.
  - Refresh counter width is $clog2(NUM_REF+1).
  - No wrap-around is possible.
- Config sampling: cfg_* values are sampled on entry to the corresponding wait or command state. Changes elsewhere are ignored.
- Abort: sdram_en=0 in any state means the next cycle is IDLE with reset output values (init_done=0). A new rising edge restarts from PWR_WAIT.
- Reset mid-sequence: reset overrides everything, including a simultaneous sdram_en rise.
- sdram_en held high in DONE: stays in DONE with no re-init.
- Total latency from the rising edge to init_done (CMD_HOLD=2, NUM_REF=2): INIT_WAIT + 2 + trp + 2×(2+trfc) + 2 + tmrd cycles.

Decomposition:
- Package sdram_init_pkg holds:
  - state enum typedef;
  - 3-bit command typedef with localparams CMD_NOP/CMD_PRE/CMD_REF/CMD_LMR;
  - the addr[10] auto-precharge bit index.
- Sub-module sdram_cmd_drv: registered encoder from command enum plus addr/ba to the pin outputs. The FSM and counters stay in the top module.

Test Plan:
- Basic init: INIT_WAIT=16, trp=2, trfc=4, tmrd=2; reset, then raise sdram_en.
  - Required response: 16 NOP, then PRE×2 with addr=0x400, NOP×2, REF×2, NOP×4, REF×2, NOP×4, LMR×2 with addr=cfg_mode_reg=0x033, NOP×2.
  - init_done rises at cycle 1+36 after the edge. The whitebox sdram_init assertion (INIT_WAIT=10000 build) passes.
- Zero waits: trp=trfc=tmrd=0, INIT_WAIT=16 -> PRE, REF, REF and LMR are back-to-back with no NOP gaps; init_done at cycle 1+24.
- Abort: drop sdram_en during the second REF -> next cycle NOP with cke=0, init_busy=0, init_done=0. Re-raising sdram_en restarts with the full 16 NOPs.
- Reset mid-operation: assert sdram_resetn=0 during PWR_WAIT at count 7 -> next cycle shows all reset values. sdram_en held high with no new edge stays in IDLE.
- Config change: alter cfg_trfc_d from 4 to 1 during PWR_WAIT -> both TRFC gaps are 1 cycle. Alter it during TRFC -> the current gap is unchanged and the next gap uses the new value.
- Sticky done: hold sdram_en=1 for 100 cycles after DONE -> init_done stays 1, pins stay NOP, no further PRE/REF/LMR.

Source files
------------

// File: rtl/sdram_init_pkg.sv
// Shared types and constants for the SDRAM power-up initialization sequencer.
package sdram_init_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PWR_WAIT,
        ST_PRE,
        ST_TRP,
        ST_REF,
        ST_TRFC,
        ST_LMR,
        ST_TMRD,
        ST_DONE
    } init_state_t;

    // {ras_n, cas_n, we_n}
    typedef logic [2:0] sdr_cmd_t;

    localparam sdr_cmd_t CMD_NOP = 3'b111;
    localparam sdr_cmd_t CMD_PRE = 3'b010;
    localparam sdr_cmd_t CMD_REF = 3'b001;
    localparam sdr_cmd_t CMD_LMR = 3'b000;

    // Address bit that selects all banks on PRECHARGE.
    localparam int AP_BIT = 10;

endpackage

// File: rtl/sdram_cmd_drv.sv
// Registered pin driver: turns the sequencer's command, address and status
// into the SDRAM command pins and the init status outputs.
module sdram_cmd_drv
    import sdram_init_pkg::*;
#(
    parameter int SDR_AW = 13
) (
    input  logic              sdram_clk,
    input  logic              sdram_resetn,
    input  logic              cke,
    input  sdr_cmd_t          cmd,
    input  logic [SDR_AW-1:0] addr,
    input  logic [1:0]        ba,
    input  logic              busy,
    input  logic              done,
    output logic              init_busy,
    output logic              init_done,
    output logic              sdr_cke,
    output logic              sdr_cs_n,
    output logic              sdr_ras_n,
    output logic              sdr_cas_n,
    output logic              sdr_we_n,
    output logic [SDR_AW-1:0] sdr_addr,
    output logic [1:0]        sdr_ba
);

    always_ff @(posedge sdram_clk) begin
        if (!sdram_resetn) begin
            init_busy <= 1'b0;
            init_done <= 1'b0;
            sdr_cke   <= 1'b0;
            sdr_cs_n  <= 1'b0;
            {sdr_ras_n, sdr_cas_n, sdr_we_n} <= CMD_NOP;
            sdr_addr  <= '0;
            sdr_ba    <= '0;
        end else begin
            init_busy <= busy;
            init_done <= done;
            sdr_cke   <= cke;
            sdr_cs_n  <= 1'b0;
            {sdr_ras_n, sdr_cas_n, sdr_we_n} <= cmd;
            sdr_addr  <= addr;
            sdr_ba    <= ba;
        end
    end

endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up init sequencer: NOP wait, PRECHARGE ALL, NUM_REF refreshes,
// LOAD MODE REGISTER, then a sticky init_done until sdram_en drops.
module sdram_init_seq
    import sdram_init_pkg::*;
#(
    parameter int SDR_AW    = 13,
    parameter int INIT_WAIT = 10000,
    parameter int CMD_HOLD  = 2,
    parameter int NUM_REF   = 2
) (
    input  logic              sdram_clk,
    input  logic              sdram_resetn,
    input  logic              sdram_en,
    input  logic [SDR_AW-1:0] cfg_mode_reg,
    input  logic [3:0]        cfg_trp_d,
    input  logic [3:0]        cfg_trfc_d,
    input  logic [3:0]        cfg_tmrd_d,
    output logic              init_busy,
    output logic              init_done,
    output logic              sdr_cke,
    output logic              sdr_cs_n,
    output logic              sdr_ras_n,
    output logic              sdr_cas_n,
    output logic              sdr_we_n,
    output logic [SDR_AW-1:0] sdr_addr,
    output logic [1:0]        sdr_ba
);

    localparam int WW = $clog2(INIT_WAIT + 1);
    localparam int RW = $clog2(NUM_REF + 1);

    init_state_t       state_reg, state_next;
    logic              en_q_reg;
    logic [WW-1:0]     wait_cnt_reg, wait_load;
    logic [RW-1:0]     ref_cnt_reg;
    logic [SDR_AW-1:0] mode_reg_q;

    logic              rise, wait_done, last_ref, enter, ref_inc;
    sdr_cmd_t          cmd_next;
    logic [SDR_AW-1:0] addr_next;
    logic              cke_next, busy_next, done_next;

    assign rise      = sdram_en && !en_q_reg;
    assign wait_done = (wait_cnt_reg == '0);
    assign last_ref  = (ref_cnt_reg == RW'(NUM_REF - 1));

    always_comb begin
        state_next = state_reg;
        enter      = 1'b0;
        ref_inc    = 1'b0;
        case (state_reg)
            ST_IDLE: if (rise) begin
                state_next = ST_PWR_WAIT;
                enter      = 1'b1;
            end
            ST_PWR_WAIT: if (wait_done) begin
                state_next = ST_PRE;
                enter      = 1'b1;
            end
            ST_PRE: if (wait_done) begin
                state_next = (cfg_trp_d != '0) ? ST_TRP : ST_REF;
                enter      = 1'b1;
            end
            ST_TRP: if (wait_done) begin
                state_next = ST_REF;
                enter      = 1'b1;
            end
            ST_REF: if (wait_done) begin
                enter = 1'b1;
                if (cfg_trfc_d != '0) begin
                    state_next = ST_TRFC;
                end else begin
                    ref_inc    = 1'b1;
                    state_next = last_ref ? ST_LMR : ST_REF;
                end
            end
            ST_TRFC: if (wait_done) begin
                enter      = 1'b1;
                ref_inc    = 1'b1;
                state_next = last_ref ? ST_LMR : ST_REF;
            end
            ST_LMR: if (wait_done) begin
                state_next = (cfg_tmrd_d != '0) ? ST_TMRD : ST_DONE;
                enter      = 1'b1;
            end
            ST_TMRD: if (wait_done) begin
                state_next = ST_DONE;
                enter      = 1'b1;
            end
            default: state_next = state_reg;
        endcase
        if (!sdram_en) begin
            state_next = ST_IDLE;
            enter      = 1'b0;
            ref_inc    = 1'b0;
        end
    end

    // Reload value for the state being entered; cfg delays are captured here.
    always_comb begin
        wait_load = '0;
        case (state_next)
            ST_PWR_WAIT:           wait_load = WW'(INIT_WAIT - 1);
            ST_PRE, ST_REF, ST_LMR: wait_load = WW'(CMD_HOLD - 1);
            ST_TRP:                wait_load = WW'(cfg_trp_d) - WW'(1);
            ST_TRFC:               wait_load = WW'(cfg_trfc_d) - WW'(1);
            ST_TMRD:               wait_load = WW'(cfg_tmrd_d) - WW'(1);
            default:               wait_load = '0;
        endcase
    end

    // en_q follows sdram_en even in reset so a level held through reset is not an edge.
    always_ff @(posedge sdram_clk) begin
        en_q_reg <= sdram_en;
        if (!sdram_resetn) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
            ref_cnt_reg  <= '0;
            mode_reg_q   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_next == ST_IDLE) begin
                wait_cnt_reg <= '0;
                ref_cnt_reg  <= '0;
            end else begin
                if (enter)
                    wait_cnt_reg <= wait_load;
                else if (!wait_done)
                    wait_cnt_reg <= wait_cnt_reg - WW'(1);
                if (ref_inc)
                    ref_cnt_reg <= ref_cnt_reg + RW'(1);
            end
            if (enter && state_next == ST_LMR)
                mode_reg_q <= cfg_mode_reg;
        end
    end

    always_comb begin
        cmd_next  = CMD_NOP;
        addr_next = '0;
        cke_next  = (state_reg != ST_IDLE);
        busy_next = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
        done_next = (state_reg == ST_DONE);
        case (state_reg)
            ST_PRE: begin
                cmd_next          = CMD_PRE;
                addr_next[AP_BIT] = 1'b1;
            end
            ST_REF: cmd_next = CMD_REF;
            ST_LMR: begin
                cmd_next  = CMD_LMR;
                addr_next = mode_reg_q;
            end
            default: cmd_next = CMD_NOP;
        endcase
        // An abort shows idle pins on the same edge the FSM returns to IDLE.
        if (!sdram_en) begin
            cmd_next  = CMD_NOP;
            addr_next = '0;
            cke_next  = 1'b0;
            busy_next = 1'b0;
            done_next = 1'b0;
        end
    end

    sdram_cmd_drv #(
        .SDR_AW(SDR_AW)
    ) u_cmd_drv (
        .sdram_clk    (sdram_clk),
        .sdram_resetn (sdram_resetn),
        .cke          (cke_next),
        .cmd          (cmd_next),
        .addr         (addr_next),
        .ba           (2'b00),
        .busy         (busy_next),
        .done         (done_next),
        .init_busy    (init_busy),
        .init_done    (init_done),
        .sdr_cke      (sdr_cke),
        .sdr_cs_n     (sdr_cs_n),
        .sdr_ras_n    (sdr_ras_n),
        .sdr_cas_n    (sdr_cas_n),
        .sdr_we_n     (sdr_we_n),
        .sdr_addr     (sdr_addr),
        .sdr_ba       (sdr_ba)
    );

endmodule

// File: tb/tb_sdram_init_seq.sv
// Self-checking bench for sdram_init_seq: expected pin stream per cycle is
// queued when a sequence starts and compared on each falling edge.
module tb_sdram_init_seq;

    localparam int AW = 13;
    localparam int IW = 16;

    logic          sdram_clk = 1'b0;
    logic          sdram_resetn = 1'b0;
    logic          sdram_en = 1'b0;
    logic [AW-1:0] cfg_mode_reg = '0;
    logic [3:0]    cfg_trp_d = '0, cfg_trfc_d = '0, cfg_tmrd_d = '0;
    logic          init_busy, init_done, sdr_cke, sdr_cs_n;
    logic          sdr_ras_n, sdr_cas_n, sdr_we_n;
    logic [AW-1:0] sdr_addr;
    logic [1:0]    sdr_ba;

    sdram_init_seq #(
        .SDR_AW(AW), .INIT_WAIT(IW), .CMD_HOLD(2), .NUM_REF(2)
    ) dut (
        .sdram_clk(sdram_clk), .sdram_resetn(sdram_resetn), .sdram_en(sdram_en),
        .cfg_mode_reg(cfg_mode_reg), .cfg_trp_d(cfg_trp_d), .cfg_trfc_d(cfg_trfc_d),
        .cfg_tmrd_d(cfg_tmrd_d), .init_busy(init_busy), .init_done(init_done),
        .sdr_cke(sdr_cke), .sdr_cs_n(sdr_cs_n), .sdr_ras_n(sdr_ras_n),
        .sdr_cas_n(sdr_cas_n), .sdr_we_n(sdr_we_n), .sdr_addr(sdr_addr), .sdr_ba(sdr_ba)
    );

    always #5 sdram_clk = ~sdram_clk;

    localparam logic [2:0] NOP = 3'b111, PRE = 3'b010, REF = 3'b001, LMR = 3'b000;

    typedef struct packed {
        logic          cke;
        logic          cs_n;
        logic [2:0]    cmd;
        logic [AW-1:0] addr;
        logic [1:0]    ba;
        logic          busy;
        logic          done;
    } pins_t;

    typedef struct {
        logic [3:0]    trp;
        logic [3:0]    trfc;
        logic [3:0]    tmrd;
        logic [AW-1:0] mode;
        int            extra;
        int            done_cyc;
    } vec_t;

    pins_t sb[$];
    vec_t  vecs[4];
    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    first_done = -1;

    function automatic pins_t mk(logic cke, logic [2:0] cmd, logic [AW-1:0] addr,
                                 logic busy, logic done);
        pins_t p;
        p.cke  = cke;
        p.cs_n = 1'b0;
        p.cmd  = cmd;
        p.addr = addr;
        p.ba   = 2'b00;
        p.busy = busy;
        p.done = done;
        return p;
    endfunction

    task automatic push_n(input pins_t p, input int n);
        for (int i = 0; i < n; i++) sb.push_back(p);
    endtask

    // Expected pins from the cycle of the enable edge onward.
    task automatic push_init(input int trp, input int trfc_a, input int trfc_b,
                             input int tmrd, input logic [AW-1:0] mode, input int extra);
        push_n(mk(1'b0, NOP, '0, 1'b0, 1'b0), 1);
        push_n(mk(1'b1, NOP, '0, 1'b1, 1'b0), IW);
        push_n(mk(1'b1, PRE, 13'h400, 1'b1, 1'b0), 2);
        push_n(mk(1'b1, NOP, '0, 1'b1, 1'b0), trp);
        push_n(mk(1'b1, REF, '0, 1'b1, 1'b0), 2);
        push_n(mk(1'b1, NOP, '0, 1'b1, 1'b0), trfc_a);
        push_n(mk(1'b1, REF, '0, 1'b1, 1'b0), 2);
        push_n(mk(1'b1, NOP, '0, 1'b1, 1'b0), trfc_b);
        push_n(mk(1'b1, LMR, mode, 1'b1, 1'b0), 2);
        push_n(mk(1'b1, NOP, '0, 1'b1, 1'b0), tmrd);
        push_n(mk(1'b1, NOP, '0, 1'b0, 1'b1), extra);
    endtask

    function automatic pins_t sample();
        pins_t a;
        a = {sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n, sdr_addr, sdr_ba,
             init_busy, init_done};
        return a;
    endfunction

    task automatic check_pins(input string name, input pins_t act, input pins_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got cke=%b cs_n=%b cmd=%b addr=%h ba=%0d busy=%b done=%b expected cke=%b cs_n=%b cmd=%b addr=%h ba=%0d busy=%b done=%b",
                     name, cyc, act.cke, act.cs_n, act.cmd, act.addr, act.ba, act.busy, act.done,
                     exp.cke, exp.cs_n, exp.cmd, exp.addr, exp.ba, exp.busy, exp.done);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drain(input string name, input int n);
        pins_t exp;
        pins_t act;
        for (int i = 0; i < n && sb.size() > 0; i++) begin
            @(negedge sdram_clk);
            exp = sb.pop_front();
            act = sample();
            if (act.done && first_done < 0) first_done = cyc;
            check_pins(name, act, exp);
            cyc++;
        end
    endtask

    task automatic start();
        sdram_en   = 1'b1;
        cyc        = 0;
        first_done = -1;
    endtask

    task automatic do_reset();
        @(negedge sdram_clk);
        sdram_resetn = 1'b0;
        sdram_en     = 1'b0;
        @(negedge sdram_clk);
        @(negedge sdram_clk);
        sdram_resetn = 1'b1;
        check_pins("reset_vals", sample(), mk(1'b0, NOP, '0, 1'b0, 1'b0));
        sb.delete();
    endtask

    task automatic set_cfg(input int trp, input int trfc, input int tmrd, input logic [AW-1:0] mode);
        cfg_trp_d    = 4'(trp);
        cfg_trfc_d   = 4'(trfc);
        cfg_tmrd_d   = 4'(tmrd);
        cfg_mode_reg = mode;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{trp: 4'd2, trfc: 4'd4, tmrd: 4'd2, mode: 13'h033, extra: 100, done_cyc: 37};
        vecs[1] = '{trp: 4'd0, trfc: 4'd0, tmrd: 4'd0, mode: 13'h155, extra: 3,   done_cyc: 25};
        vecs[2] = '{trp: 4'd1, trfc: 4'd3, tmrd: 4'd0, mode: 13'h1aa, extra: 3,   done_cyc: 32};
        vecs[3] = '{trp: 4'd0, trfc: 4'd2, tmrd: 4'd5, mode: 13'h0f0, extra: 3,   done_cyc: 34};

        for (int v = 0; v < 4; v++) begin
            do_reset();
            set_cfg(int'(vecs[v].trp), int'(vecs[v].trfc), int'(vecs[v].tmrd), vecs[v].mode);
            push_init(int'(vecs[v].trp), int'(vecs[v].trfc), int'(vecs[v].trfc),
                      int'(vecs[v].tmrd), vecs[v].mode, vecs[v].extra);
            start();
            drain($sformatf("vec%0d", v), sb.size());
            check_int($sformatf("vec%0d_done_cycle", v), first_done, vecs[v].done_cyc);
        end

        // Abort during the second REF, then restart with the full wait.
        do_reset();
        set_cfg(2, 4, 2, 13'h033);
        push_init(2, 4, 4, 2, 13'h033, 0);
        while (sb.size() > 28) void'(sb.pop_back());
        start();
        drain("abort_pre", 28);
        sdram_en = 1'b0;
        push_n(mk(1'b0, NOP, '0, 1'b0, 1'b0), 3);
        drain("abort_idle", 3);
        push_init(2, 4, 4, 2, 13'h033, 2);
        start();
        drain("abort_restart", sb.size());
        check_int("abort_restart_done_cycle", first_done, 37);

        // Reset during PWR_WAIT with sdram_en held high afterwards.
        do_reset();
        push_init(2, 4, 4, 2, 13'h033, 0);
        while (sb.size() > 9) void'(sb.pop_back());
        start();
        drain("rst_mid_pre", 9);
        sdram_resetn = 1'b0;
        push_n(mk(1'b0, NOP, '0, 1'b0, 1'b0), 1);
        drain("rst_mid_vals", 1);
        sdram_resetn = 1'b1;
        push_n(mk(1'b0, NOP, '0, 1'b0, 1'b0), 5);
        drain("rst_mid_hold_idle", 5);

        // trfc changed during PWR_WAIT: both gaps use the new value.
        do_reset();
        set_cfg(2, 4, 2, 13'h033);
        push_init(2, 1, 1, 2, 13'h033, 2);
        start();
        drain("cfg_pwr", 6);
        cfg_trfc_d = 4'd1;
        drain("cfg_pwr", sb.size());
        check_int("cfg_pwr_done_cycle", first_done, 31);

        // trfc changed inside the first TRFC gap: only the second gap changes.
        do_reset();
        set_cfg(2, 4, 2, 13'h033);
        push_init(2, 4, 1, 2, 13'h033, 2);
        start();
        drain("cfg_trfc", 25);
        cfg_trfc_d = 4'd1;
        drain("cfg_trfc", sb.size());
        check_int("cfg_trfc_done_cycle", first_done, 34);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
